// File: rtl/foc_prod_shift_sat.sv
// foc_prod_shift_sat
//   Rescales the signed product from the FOC multiplier by an arithmetic right
//   shift of SHIFT bits. The result is saturated to DOUT_WIDTH signed bits and
//   delivered over a valid/ready handshake. The block is a two-stage pipeline
//   (A: shift, B: saturate). A saturating counter records how many clipped
//   outputs were delivered.
//
//   Build option: define FOC_PROD_SHIFT_ROUND_EN to round half-up (add
//   2^(SHIFT-1) before the shift). Without it the shift truncates toward -inf.
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   asynchronous reset, active-low
//   din       in   signed product [DIN_WIDTH]
//   din_vld   in   din valid
//   din_rdy   out  din accepted this cycle when din_vld is high
//   dout      out  scaled, saturated result [DOUT_WIDTH]
//   dout_sat  out  current dout was clipped
//   dout_vld  out  dout valid
//   dout_rdy  in   downstream accepts dout
//   clr_cnt   in   synchronous clear of sat_cnt (wins over increment)
//   sat_cnt   out  saturating count of clipped outputs delivered [CNT_WIDTH]
module foc_prod_shift_sat #(
  parameter int DIN_WIDTH  = 34,
  parameter int DOUT_WIDTH = 16,
  parameter int SHIFT      = 15,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DIN_WIDTH-1:0]  din,
  input  logic                         din_vld,
  output logic                         din_rdy,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         dout_sat,
  output logic                         dout_vld,
  input  logic                         dout_rdy,
  input  logic                         clr_cnt,
  output logic [CNT_WIDTH-1:0]         sat_cnt
);

  // Width of the shifted value in stage A
  localparam int W = DIN_WIDTH + 1 - SHIFT;

  localparam logic signed [DOUT_WIDTH-1:0] OUT_MAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [DOUT_WIDTH-1:0] OUT_MIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

  logic                         r_a_vld;
  logic signed [W-1:0]          r_a_val;
  logic signed [DOUT_WIDTH-1:0] r_dout;
  logic                         r_dout_sat;
  logic                         r_dout_vld;
  logic [CNT_WIDTH-1:0]         r_sat_cnt;

  logic                         w_b_en;
  logic                         w_a_en;
  logic signed [DIN_WIDTH:0]    w_ext;
  logic signed [DIN_WIDTH:0]    w_sum;
  logic signed [W-1:0]          w_a_next;
  logic                         w_unused_lsb;
  logic [W-DOUT_WIDTH:0]        w_hi;
  logic                         w_ovf;
  logic signed [DOUT_WIDTH-1:0] w_b_next;
  logic                         w_b_sat;
  logic                         w_sat_xfer;

  // Handshake: an empty stage always loads, so bubbles collapse
  assign w_b_en  = !r_dout_vld || dout_rdy;
  assign w_a_en  = !r_a_vld || w_b_en;
  assign din_rdy = w_a_en;

  // One guard bit so the rounding add can never overflow
  assign w_ext = {din[DIN_WIDTH-1], din};

`ifdef FOC_PROD_SHIFT_ROUND_EN
  localparam logic signed [DIN_WIDTH:0] RND = {{DIN_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  assign w_sum = w_ext + RND;
`else
  assign w_sum = w_ext;
`endif

  // Selecting the upper W bits is the arithmetic shift; the dropped upper
  // bits of a full >>> would only be sign copies
  assign w_a_next     = w_sum[DIN_WIDTH:SHIFT];
  assign w_unused_lsb = ^w_sum[SHIFT-1:0];

  // Value fits in DOUT_WIDTH iff all bits from the output sign bit upward agree
  assign w_hi  = r_a_val[W-1:DOUT_WIDTH-1];
  assign w_ovf = !((&w_hi) || !(|w_hi));

  always_comb begin
    w_b_next = r_a_val[DOUT_WIDTH-1:0];
    w_b_sat  = 1'b0;
    if (w_ovf) begin
      w_b_sat  = 1'b1;
      w_b_next = r_a_val[W-1] ? OUT_MIN : OUT_MAX;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a_vld <= 1'b0;
      r_a_val <= '0;
    end else if (w_a_en) begin
      r_a_vld <= din_vld;
      if (din_vld) begin
        r_a_val <= w_a_next;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dout_vld <= 1'b0;
      r_dout     <= '0;
      r_dout_sat <= 1'b0;
    end else if (w_b_en) begin
      r_dout_vld <= r_a_vld;
      if (r_a_vld) begin
        r_dout     <= w_b_next;
        r_dout_sat <= w_b_sat;
      end
    end
  end

  assign w_sat_xfer = r_dout_vld && dout_rdy && r_dout_sat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sat_cnt <= '0;
    end else if (clr_cnt) begin
      r_sat_cnt <= '0;
    end else if (w_sat_xfer && (r_sat_cnt != '1)) begin
      r_sat_cnt <= r_sat_cnt + 1'b1;
    end
  end

  assign dout     = r_dout;
  assign dout_sat = r_dout_sat;
  assign dout_vld = r_dout_vld;
  assign sat_cnt  = r_sat_cnt;

endmodule

// File: doc/foc_prod_shift_sat.md
Name: foc_prod_shift_sat

Overview:
- Downstream consumer of the 16s x 17ns -> 34-bit signed product multiplier in the FOC datapath.
- Takes the raw 34-bit product and rescales it by an arithmetic right shift (Q15 by default), with optional round-half-up.
- Saturates the result to a 16-bit signed value and delivers it over a valid/ready handshake.
- Counts saturation events for firmware diagnostics.

Parameters:
- DIN_WIDTH, 34, product input width (signed).
- DOUT_WIDTH, 16, output width (signed).
- SHIFT, 15, arithmetic right-shift amount. Legal range: 1 <= SHIFT < DIN_WIDTH, and DIN_WIDTH+1-SHIFT >= DOUT_WIDTH.
- CNT_WIDTH, 16, width of the saturation event counter.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous reset, active-low.
- din  in  DIN_WIDTH  signed product from the multiplier.
- din_vld  in  1  din valid.
- din_rdy  out  1  block can accept din this cycle.
- dout  out  DOUT_WIDTH  scaled, saturated signed result.
- dout_sat  out  1  the current dout was clipped.
- dout_vld  out  1  dout valid.
- dout_rdy  in  1  downstream accepts dout.
- clr_cnt  in  1  synchronous clear of sat_cnt.
- sat_cnt  out  CNT_WIDTH  saturating count of clipped outputs delivered.

Behaviour:
- Reset (reset=0, asynchronous): stage A and stage B valid flags cleared; dout=0, dout_sat=0, dout_vld=0, sat_cnt=0. din_rdy=1 once the valid flags are clear. Reset mid-stream discards in-flight samples; the first cycle after release behaves as an empty pipeline.
- Two-stage pipeline, A then B. Stage B registers are dout/dout_sat/dout_vld directly.
- Enables:
  - B_en = !dout_vld | dout_rdy
  - A_en = !A_vld | B_en
  - din_rdy = A_en (combinational from dout_rdy; no registered-ready requirement)
- Bubbles collapse: an empty stage always loads.
- Input transfer: din_vld & din_rdy at an edge. Output transfer: dout_vld & dout_rdy at an edge.
- Stage A, on A_en:
  - A_vld <= din_vld.
  - If din_vld: A_val <= (sext(din, DIN_WIDTH+1) + R) >>> SHIFT, where R = 2^(SHIFT-1) with rounding or 0 without.
  - The DIN_WIDTH+1 width guarantees no overflow on the add.
  - Result width W = DIN_WIDTH+1-SHIFT.
- Stage B, on B_en:
  - dout_vld <= A_vld.
  - If A_vld:
    - A_val > 2^(DOUT_WIDTH-1)-1: dout = max (32767), dout_sat = 1.
    - A_val < -2^(DOUT_WIDTH-1): dout = min (-32768), dout_sat = 1.
    - Otherwise: dout = A_val[DOUT_WIDTH-1:0], dout_sat = 0.
- dout and dout_sat hold stable while dout_vld & !dout_rdy.
- Latency: 2 cycles from input transfer to dout_vld with no backpressure. Throughput 1 sample/cycle when dout_rdy=1.
- Capacity: 2 samples (A and B). With dout_rdy held low, din_rdy drops after the 2nd accepted sample. Order is preserved; no loss or duplication.
- sat_cnt:
  - On an output transfer with dout_sat=1: sat_cnt increments by 1.
  - Saturates at 2^CNT_WIDTH-1; does not wrap.
  - clr_cnt=1 sets sat_cnt to 0 at the edge and has priority over a simultaneous increment.
- Output data while dout_vld=0 is don't-care for the bench except after reset (0).

Optional Feature:
- Macro: FOC_PROD_SHIFT_ROUND_EN.
- Defined: R = 2^(SHIFT-1), i.e. round-half-up (toward +inf on ties).
- Undefined: R = 0, i.e. pure arithmetic shift (floor truncation). The adder is removed; stage A is a register on the shifted value only.
- Pipeline latency and handshake are identical in both builds.

Test Plan:
- Rounding tie, default params, dout_rdy=1: din=16384 (0x4000) -> dout=1 with ROUND_EN, 0 without; dout_sat=0; dout_vld 2 cycles after acceptance.
- Negative tie: din=-16384 -> dout=0 with ROUND_EN, -1 without; dout_sat=0.
- Saturation:
  - din=2^30 -> dout=32767, dout_sat=1.
  - din=-2^31 -> dout=-32768, dout_sat=1.
  - sat_cnt goes 0->1->2 on the two output transfers.
- Backpressure: dout_rdy=0, drive din 1*32768, 2*32768, 3*32768, 4*32768 continuously -> only 2 accepted, din_rdy=0. Release dout_rdy -> outputs 1,2,3,4 in order; no gaps once flowing; no duplicates.
- Counter edges, CNT_WIDTH=2:
  - Five saturating outputs -> sat_cnt=3 (holds).
  - clr_cnt=1 in the same cycle as a saturating transfer -> sat_cnt=0.
- Async reset mid-stream with A and B both valid and dout_rdy=0: reset low between edges -> dout_vld=0, sat_cnt=0 immediately. After release, din_rdy=1 and the next din=32768 yields dout=1 two cycles later.
